muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have input iCLK, 1 bit: clock; all state changes on the rising edge.
REQ-003 SHALL have input iRST, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have input iStart, 1 bit: request strobe, sampled each rising edge.
REQ-005 SHALL have input iOp, 5 bits: ALU operation code; shared ALUOP encoding.
REQ-006 SHALL have inputs iA and iB, 32 bits each: operands (rs, rt).
REQ-007 SHALL have output oBusy, 1 bit: iterative operation in progress.
REQ-008 SHALL have output oDone, 1 bit: one-cycle pulse, new HI/LO valid.
REQ-009 SHALL have outputs oHI and oLO, 32 bits each: HI and LO register contents, read by the ALU for MFHI/MFLO.

Function
REQ-010 SHALL implement states IDLE, RUN and FIX; oBusy = (state != IDLE).
REQ-011 SHALL accept a request only in IDLE with iStart=1; iStart while busy is ignored, with no queueing.
REQ-012 SHALL, on acceptance of MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB or MSUBU (edge E0):
  - latch iOp, the operand magnitudes and the sign flags;
  - clear the 5-bit step counter;
  - go to RUN.
REQ-013 SHALL, in RUN, perform one radix-2 step per cycle:
  - multiply: shift-add;
  - divide: restoring shift-subtract.
  RUN SHALL last exactly 32 cycles; on counter=31 it goes to FIX.
REQ-014 SHALL, in FIX (one cycle):
  - apply sign correction;
  - apply the accumulate (MADD/MADDU: {HI,LO}+product; MSUB/MSUBU: {HI,LO}-product, modulo 2^64);
  - write HI/LO on the exit edge E33;
  - return to IDLE.
REQ-015 SHALL pulse oDone high for exactly the cycle after E33, with oHI/oLO already showing the new values; a new iStart in that cycle SHALL be accepted (back-to-back).
REQ-016 SHALL compute MULT/MADD/MSUB as a signed 64-bit product and MULTU/MADDU/MSUBU as an unsigned one.
REQ-017 SHALL compute DIV with the quotient truncated toward zero into LO and the remainder, carrying the dividend's sign, into HI; DIVU is unsigned.
REQ-018 SHALL, on divide by zero, produce LO=32'hFFFFFFFF and HI=iA (signed DIV: HI equals the dividend unchanged); it is not an error and timing is unchanged.
REQ-019 SHALL, for DIV 32'h80000000 / 32'hFFFFFFFF, produce LO=32'h80000000 and HI=0.
REQ-020 SHALL, for MTHI/MTLO accepted in IDLE, write iA to HI/LO on the same edge, with no busy and no oDone pulse.
REQ-021 SHALL ignore any other iOp with iStart=1, leaving the state unchanged.
REQ-022 SHALL hold HI/LO stable during RUN/FIX; intermediate results never appear on oHI/oLO.
REQ-023 SHALL not use iA/iB after E0; operand changes during RUN have no effect.

Reset
REQ-024 SHALL, on iRST=1 at an edge, set state=IDLE, HI=LO=0, oBusy=0, oDone=0 and counter=0.
REQ-025 SHALL, on reset mid-operation, abort with no partial HI/LO write; iRST takes priority over iStart on the same edge.

Structure
REQ-026 SHALL take the ALUOP codes and the state encoding (IDLE/RUN/FIX) from the shared package; no local redefinition.
REQ-027 SHALL use a single sub-module, muldiv_step: a combinational one-iteration shift-add/shift-subtract datapath, instantiated once.
REQ-028 SHALL keep all sequential logic (state, counter, HI/LO, oDone) in muldiv_unit.

Verification
REQ-029 SHALL cover MULT with iA=-3, iB=7 -> oBusy high for 33 cycles, then oDone pulse with HI=32'hFFFFFFFF and LO=32'hFFFFFFEB.
REQ-030 SHALL cover DIV with iA=-7, iB=2 -> LO=32'hFFFFFFFD and HI=32'hFFFFFFFF; DIVU with iA=7, iB=0 -> LO=32'hFFFFFFFF and HI=7.
REQ-031 SHALL cover MTLO 5, then MADDU with iA=iB=32'hFFFFFFFF -> HI=32'hFFFFFFFE and LO=32'h00000006.
REQ-032 SHALL cover iStart with MULTU asserted at cycle 10 of RUN -> ignored; only the first result is written, and only one oDone pulse occurs.
REQ-033 SHALL cover iRST at cycle 20 of DIVU -> next cycle oBusy=0, HI=LO=0 and no oDone pulse.
REQ-034 SHALL cover back-to-back MULT issued in the oDone cycle -> accepted, with the second oDone exactly 34 cycles after the first.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - alu_op_e    : ALU operation codes (shared ALUOP encoding)
//   - md_state_e  : sequencer state encoding (IDLE / RUN / FIX)
//   - STEP_W / LAST_STEP : iteration counter width and terminal count
//   - helper functions classifying ALU ops for the mul/div unit
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

  localparam int               STEP_W    = 5;
  localparam logic [STEP_W-1:0] LAST_STEP = 5'd31;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'h00,
    ALU_SUB   = 5'h01,
    ALU_AND   = 5'h02,
    ALU_OR    = 5'h03,
    ALU_XOR   = 5'h04,
    ALU_SLT   = 5'h05,
    ALU_MULT  = 5'h10,
    ALU_MULTU = 5'h11,
    ALU_DIV   = 5'h12,
    ALU_DIVU  = 5'h13,
    ALU_MADD  = 5'h14,
    ALU_MADDU = 5'h15,
    ALU_MSUB  = 5'h16,
    ALU_MSUBU = 5'h17,
    ALU_MTHI  = 5'h18,
    ALU_MTLO  = 5'h19
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // Operations that run through the 32-step iterative datapath.
  function automatic logic is_iter_op(input logic [4:0] op);
    case (op)
      ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU,
      ALU_MADD, ALU_MADDU, ALU_MSUB, ALU_MSUBU: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    case (op)
      ALU_DIV, ALU_DIVU: return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

  // Signed variants: operands are converted to magnitude + sign flag.
  function automatic logic is_signed_op(input logic [4:0] op);
    case (op)
      ALU_MULT, ALU_MADD, ALU_MSUB, ALU_DIV: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Combinational single radix-2 iteration on the {ph, pl} working register.
//   Multiply (shift-add): pl holds the remaining multiplier bits, ph the
//     partial product upper half; opnd is the multiplicand magnitude.
//   Divide (restoring):   pl holds the remaining dividend bits / growing
//     quotient, ph the partial remainder; opnd is the divisor magnitude.
// Ports:
//   is_div_i : 1 = divide step, 0 = multiply step
//   ph_i/pl_i: current working register halves
//   opnd_i   : multiplicand or divisor magnitude
//   ph_o/pl_o: working register after one step
// -----------------------------------------------------------------------------
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] ph_i,
  input  logic [WIDTH-1:0] pl_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] ph_o,
  output logic [WIDTH-1:0] pl_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_sub;
  logic             sub_unused_msb;
  logic             borrow;

  // NOTE: every signal written here gets a value on every path (defaults
  // first), otherwise synthesis infers a latch.
  always_comb begin
    sum            = {1'b0, ph_i} + (pl_i[0] ? {1'b0, opnd_i} : '0);
    shifted        = {ph_i, pl_i[WIDTH-1]};
    borrow         = (shifted < {1'b0, opnd_i});
    // When no borrow the difference is below the divisor, so it fits WIDTH bits.
    {sub_unused_msb, rem_sub} = shifted - {1'b0, opnd_i};
    ph_o           = sum[WIDTH:1];
    pl_o           = {sum[0], pl_i[WIDTH-1:1]};
    if (is_div_i) begin
      ph_o = borrow ? shifted[WIDTH-1:0] : rem_sub;
      pl_o = {pl_i[WIDTH-2:0], ~borrow};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative 32-bit multiply / divide unit owning the HI/LO registers.
// A request is accepted in IDLE; iterative ops spend 32 cycles in RUN (one
// radix-2 step each) and one cycle in FIX (sign correction, accumulate),
// then HI/LO are written and oDone pulses for one cycle. MTHI/MTLO write
// HI/LO directly in IDLE.
// Ports:
//   iCLK, iRST   : clock, synchronous active-high reset
//   iStart       : request strobe
//   iOp          : ALU operation code (alu_op_e)
//   iA, iB       : operands (rs, rt)
//   oBusy        : iterative operation in progress
//   oDone        : one-cycle pulse, new HI/LO visible
//   oHI, oLO     : HI / LO register contents
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [4:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO
);

  md_state_e          state_q, state_d;
  logic [STEP_W-1:0]  cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  alu_op_e            op_q;
  logic [WIDTH-1:0]   opnd_q, ph_q, pl_q;
  logic               neg_a_q, neg_b_q;

  logic               accept_iter;
  logic               op_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   step_ph, step_pl;

  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quot, rem;
  logic [2*WIDTH-1:0] fix_res;

  // ---------------------------------------------------------------------------
  // Request decode and operand conditioning
  // ---------------------------------------------------------------------------
  assign accept_iter = (state_q == ST_IDLE) && iStart && is_iter_op(iOp);
  assign op_signed   = is_signed_op(iOp);
  assign a_neg       = op_signed & iA[WIDTH-1];
  assign b_neg       = op_signed & iB[WIDTH-1];
  assign mag_a       = a_neg ? -iA : iA;
  assign mag_b       = b_neg ? -iB : iB;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_iter)         state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST_STEP)  state_d = ST_FIX;
      ST_FIX:                           state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    oBusy = (state_q != ST_IDLE);
  end

  assign oDone = done_q;
  assign oHI   = hi_q;
  assign oLO   = lo_q;

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_op(op_q)),
    .ph_i     (ph_q),
    .pl_i     (pl_q),
    .opnd_i   (opnd_q),
    .ph_o     (step_ph),
    .pl_o     (step_pl)
  );

  // NOTE: the working registers carry no reset; they are always loaded on
  // acceptance before any use, and a reset returns the FSM to IDLE where
  // they are ignored.
  always_ff @(posedge iCLK) begin
    if (accept_iter) begin
      op_q    <= alu_op_e'(iOp);
      neg_a_q <= a_neg;
      neg_b_q <= b_neg;
      ph_q    <= '0;
      if (is_div_op(iOp)) begin
        opnd_q <= mag_b;
        pl_q   <= mag_a;
      end else begin
        opnd_q <= mag_a;
        pl_q   <= mag_b;
      end
    end else if (state_q == ST_RUN) begin
      ph_q <= step_ph;
      pl_q <= step_pl;
    end
  end

  // ---------------------------------------------------------------------------
  // FIX-cycle result: sign correction and accumulate
  // ---------------------------------------------------------------------------
  always_comb begin
    prod_signed = (neg_a_q ^ neg_b_q) ? -{ph_q, pl_q} : {ph_q, pl_q};
    // A zero divisor leaves an all-ones quotient; forcing it keeps LO all
    // ones for signed divides too. The remainder then equals the dividend.
    quot        = (opnd_q == '0) ? '1 : ((neg_a_q ^ neg_b_q) ? -pl_q : pl_q);
    rem         = neg_a_q ? -ph_q : ph_q;
    fix_res     = prod_signed;
    case (op_q)
      ALU_MADD, ALU_MADDU: fix_res = {hi_q, lo_q} + prod_signed;
      ALU_MSUB, ALU_MSUBU: fix_res = {hi_q, lo_q} - prod_signed;
      ALU_DIV,  ALU_DIVU:  fix_res = {rem, quot};
      default:             fix_res = prod_signed;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Step counter, HI/LO and done pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == ST_FIX);
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (iStart && (iOp == ALU_MTHI)) hi_q <= iA;
          if (iStart && (iOp == ALU_MTLO)) lo_q <= iA;
        end
        ST_RUN: cnt_q <= cnt_q + 5'd1;
        ST_FIX: {hi_q, lo_q} <= fix_res;
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: a table of directed vectors with
// hand-computed HI/LO results, plus hand-written sequences for reset, MTHI/
// MTLO, ignored ops, iStart while busy, reset mid-operation and back-to-back.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .iCLK   (clk),
    .iRST   (rst),
    .iStart (start),
    .iOp    (op),
    .iA     (a),
    .iB     (b),
    .oBusy  (busy),
    .oDone  (done),
    .oHI    (hi),
    .oLO    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [31:0] pre_hi, pre_lo;
    logic [31:0] exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One-cycle request: driven on a falling edge, sampled on the next rising edge.
  task automatic pulse_req(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; op = ALU_ADD;
    // Scramble operands after acceptance; the unit must not look at them.
    a = 32'hDEAD_BEEF; b = 32'h1357_9BDF;
  endtask

  // Issue an iterative op and wait (bounded) for oDone; returns at the done
  // falling edge. Counts busy cycles and watches HI/LO for early change.
  task automatic run_op(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb,
                        output int busy_cyc, output bit stable, output bit seen);
    logic [31:0] h0, l0;
    busy_cyc = 0; stable = 1'b1; seen = 1'b0;
    @(negedge clk);
    h0 = hi; l0 = lo;
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; op = ALU_ADD; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int  bc;
    bit  st, sn;
    int  pulses;
    logic [31:0] ph, pl;

    //            name          op         a             b             pre_hi        pre_lo        exp_hi        exp_lo
    vecs[0]  = '{"mult_m3x7",   ALU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{"multu_max2",  ALU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{"mult_minsq",  ALU_MULT,  32'h80000000, 32'h80000000, 32'h0,        32'h0,        32'h40000000, 32'h00000000};
    vecs[3]  = '{"div_m7d2",    ALU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{"div_7dm2",    ALU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD};
    vecs[5]  = '{"divu_7d0",    ALU_DIVU,  32'h00000007, 32'h00000000, 32'h0,        32'h0,        32'h00000007, 32'hFFFFFFFF};
    vecs[6]  = '{"div_m5d0",    ALU_DIV,   32'hFFFFFFFB, 32'h00000000, 32'h0,        32'h0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[7]  = '{"div_ovf",     ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00000000, 32'h80000000};
    vecs[8]  = '{"divu_big",    ALU_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0,        32'h0,        32'h0000000F, 32'h0FFFFFFF};
    vecs[9]  = '{"maddu_max",   ALU_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h00000005, 32'hFFFFFFFE, 32'h00000006};
    vecs[10] = '{"madd_neg",    ALU_MADD,  32'hFFFFFFFE, 32'h00000003, 32'h0,        32'h0000000A, 32'h00000000, 32'h00000004};
    vecs[11] = '{"msub_pos",    ALU_MSUB,  32'h00000002, 32'h00000003, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[12] = '{"msubu_brw",   ALU_MSUBU, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0,        32'h00000000, 32'h00000001};
    vecs[13] = '{"msub_m1m1",   ALU_MSUB,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};

    rst = 1'b1; start = 1'b0; op = ALU_ADD; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      pulse_req(ALU_MTHI, vecs[i].pre_hi, 32'h0);
      pulse_req(ALU_MTLO, vecs[i].pre_lo, 32'h0);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, bc, st, sn);
      check({vecs[i].name, "_done_seen"}, 64'(sn), 64'd1);
      check({vecs[i].name, "_busy_cyc"},  64'(bc), 64'd33);
      check({vecs[i].name, "_hold"},      64'(st), 64'd1);
      check({vecs[i].name, "_hi"},        64'(hi), 64'(vecs[i].exp_hi));
      check({vecs[i].name, "_lo"},        64'(lo), 64'(vecs[i].exp_lo));
      @(negedge clk);
      check({vecs[i].name, "_done_1cyc"}, 64'(done), 64'd0);
    end

    // MTHI / MTLO: direct write, no busy, no done
    @(negedge clk);
    start = 1'b1; op = ALU_MTHI; a = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi",   64'(hi),   64'h1234_5678);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    op = ALU_MTLO; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo",   64'(lo),   64'h9ABC_DEF0);
    check("mtlo_hi",   64'(hi),   64'h1234_5678);

    // Non-mul/div ops with iStart are ignored
    @(negedge clk);
    start = 1'b1; op = ALU_ADD; a = 32'h1; b = 32'h2;
    @(negedge clk);
    op = 5'h1F;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (done || busy) pulses++;
      @(negedge clk);
    end
    check("ign_activity", 64'(pulses), 64'd0);
    check("ign_hilo",     {hi, lo},    {32'h1234_5678, 32'h9ABC_DEF0});

    // iStart with MULTU at cycle 10 of RUN is ignored
    pulse_req(ALU_MULT, 32'd3, 32'd4);
    repeat (10) @(negedge clk);
    start = 1'b1; op = ALU_MULTU; a = 32'd100; b = 32'd100;
    @(negedge clk);
    start = 1'b0; op = ALU_ADD;
    pulses = 0; ph = '0; pl = '0;
    for (int k = 0; k < 80; k++) begin
      if (done) begin
        pulses++;
        ph = hi; pl = lo;
      end
      @(negedge clk);
    end
    check("busy_start_pulses", 64'(pulses), 64'd1);
    check("busy_start_result", {ph, pl},    {32'd0, 32'd12});
    check("busy_start_final",  {hi, lo},    {32'd0, 32'd12});

    // Reset at cycle 20 of DIVU aborts; reset wins over a same-edge iStart
    pulse_req(ALU_MTHI, 32'h0000_AAAA, 32'h0);
    pulse_req(ALU_MTLO, 32'h0000_5555, 32'h0);
    pulse_req(ALU_DIVU, 32'd100, 32'd7);
    repeat (20) @(negedge clk);
    check("rst_mid_busy_before", 64'(busy), 64'd1);
    rst = 1'b1; start = 1'b1; op = ALU_MULT; a = 32'd5; b = 32'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; op = ALU_ADD;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hilo", {hi, lo},  64'd0);
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      if (done || busy) pulses++;
      @(negedge clk);
    end
    check("rst_mid_quiet", 64'(pulses), 64'd0);
    check("rst_mid_hilo_after", {hi, lo}, 64'd0);

    // Back-to-back MULT issued in the oDone cycle
    run_op(ALU_MULT, 32'd5, 32'd6, bc, st, sn);
    check("b2b_first_seen", 64'(sn), 64'd1);
    check("b2b_first",      {hi, lo}, {32'd0, 32'd30});
    start = 1'b1; op = ALU_MULT; a = 32'hFFFFFFFE; b = 32'd9;
    @(negedge clk);
    start = 1'b0; op = ALU_ADD; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF;
    bc = 1; sn = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        sn = 1'b1;
        break;
      end
      bc++;
      @(negedge clk);
    end
    check("b2b_second_seen", 64'(sn), 64'd1);
    check("b2b_spacing",     64'(bc), 64'd34);
    check("b2b_second",      {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFEE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
